fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter, requests 9-bit instructions from program memory over a req/ack handshake, and presents each instruction to the decoder with a valid/stall handshake. It consumes the decoder's 4-bit condition code, together with the ALU flags and the register-file jump target, to redirect the PC on taken jumps.

## Interface
- PC_W, 8, program counter and memory address width
- RESET_PC, 0, PC value loaded on reset
- i_Clk  in  1  system clock; all state updates on the rising edge
- i_Reset  in  1  asynchronous, active-high reset
- o_Mem_Addr  out  PC_W  program memory address (current PC)
- o_Mem_Req  out  1  fetch request
- i_Mem_Ack  in  1  memory ack; i_Mem_Data valid in the same cycle
- i_Mem_Data  in  9  instruction word from memory
- o_Instruction  out  9  instruction register, to decoder
- o_Valid  out  1  o_Instruction holds an unconsumed instruction
- i_Stall  in  1  downstream not ready; the instruction is consumed on an edge where o_Valid=1 and i_Stall=0
- i_COND  in  4  condition code from the decoder for the current o_Instruction
- i_Flags  in  4  {N,C,V,Z} from the ALU flag register
- i_Jump_Addr  in  PC_W  jump target (register file read port R1, low PC_W bits)
- o_PC_Return  out  PC_W  address of the instruction following the current one; this is the call return value
- o_Halted  out  1  fetch halted; present only with FETCH_HALT_EN

## Operation
- FSM states: IDLE, REQ, ISSUE, HALT (HALT only with the macro).
- IDLE: entered on reset; unconditionally moves to REQ on the next edge.
- REQ: o_Mem_Req=1 and o_Mem_Addr=PC.
  - Address and request stay stable until an edge with i_Mem_Ack=1.
  - On that edge: IR<=i_Mem_Data, PC<=PC+1 (mod 2^PC_W), move to ISSUE.
- ISSUE: o_Valid=1 and o_Mem_Req=0.
  - While stalled, IR, PC and o_Valid hold.
  - On consumption, i_COND is evaluated and the FSM moves to REQ.
  - If the jump is taken, PC<=i_Jump_Addr; otherwise PC holds, since it already points to the next instruction.
- o_PC_Return = PC. During ISSUE this is the already-incremented value.
- Jump taken when i_COND[3]=0:
  - 0 → always
  - 1 → always (call)
  - 2 → Z
  - 3 → !Z
  - 4 → C
  - 5 → !C
  - 6 → N
  - 7 → V
- i_COND[3]=1 (e.g. 4'hF) means no jump.
- i_COND and i_Flags are sampled only on the consumption edge.
- i_Mem_Ack outside REQ is ignored.
- PC wrap-around: 2^PC_W−1 increments to 0. A jump target is taken verbatim.

## Timing
- Reset values:
  - PC=RESET_PC, IR=9'h1C0 (NOP), state=IDLE.
  - o_Mem_Req=0, o_Valid=0, o_Halted=0.
  - o_Mem_Addr=RESET_PC, o_PC_Return=RESET_PC.
- First request: o_Mem_Req rises in the second cycle after reset deasserts.
- Latency: the ack edge sets o_Valid=1 in the following cycle.
- Throughput: one instruction per 2 cycles with zero-wait memory and no stall, plus one cycle per memory wait state and per stall cycle.
- A jump costs no extra cycle: the REQ after consumption already drives the target address.
- Reset asserted mid-request: req drops immediately (asynchronous). Any outstanding request is abandoned; memory must tolerate a withdrawn req.
- Simultaneous ack and reset: reset wins and IR is not loaded.

## Configuration
- FETCH_HALT_EN defined:
  - Consuming 9'h1FF enters HALT.
  - In HALT: o_Mem_Req=0, o_Valid=0, o_Halted=1. Only reset exits.
  - Opcode 9'h1FF is otherwise a NOP, so it still reaches the decoder on its consumption edge.
- FETCH_HALT_EN undefined:
  - 9'h1FF is an ordinary NOP. No HALT state; o_Halted is not present.

## Test plan
- Reset during REQ at addr 0x05 → req drops immediately, o_Valid=0, IR=0x1C0; after release, the first req is at addr 0x00 two cycles later.
- Zero-wait memory returning 0x008,0x049,0x112, i_Stall=0, i_COND=F → addresses 0,1,2; o_Valid high every other cycle carrying those words in order.
- Ack delayed 3 cycles at addr 0x03 → o_Mem_Addr=0x03 and req held 4 cycles; o_Valid rises the cycle after ack.
- i_Stall high 4 cycles during ISSUE → o_Instruction, o_Valid and PC unchanged, no req; consumption on the first unstalled edge.
- Jumps:
  - Instruction at 0x10 with i_COND=2, Z=1, i_Jump_Addr=0x40 → next req at 0x40.
  - Same with Z=0 → next req at 0x11.
  - i_COND=1 → o_PC_Return=0x11 while valid.
- Wrap and halt:
  - PC_W=8 with a fetch at 0xFF → next req at 0x00.
  - With FETCH_HALT_EN, consume 0x1FF → o_Halted=1 and no further req until reset.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Holds the PC and fetches 9-bit words over a req/ack handshake.
// It presents each word with valid/stall and redirects the PC on taken jumps.
// Optional feature macro: FETCH_HALT_EN. When defined, consuming 9'h1FF parks
// the unit in HALT (o_Halted=1) until reset.
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  output logic [PC_W-1:0] o_Mem_Addr,
  output logic            o_Mem_Req,
  input  logic            i_Mem_Ack,
  input  logic [8:0]      i_Mem_Data,
  output logic [8:0]      o_Instruction,
  output logic            o_Valid,
  input  logic            i_Stall,
  input  logic [3:0]      i_COND,
  input  logic [3:0]      i_Flags,
  input  logic [PC_W-1:0] i_Jump_Addr,
  output logic [PC_W-1:0] o_PC_Return
`ifdef FETCH_HALT_EN
  ,
  output logic            o_Halted
`endif
);

  localparam logic [8:0]      NOP_INSTR = 9'h1C0;
  localparam logic [PC_W-1:0] PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
`ifdef FETCH_HALT_EN
  localparam logic [8:0]      HALT_INSTR = 9'h1FF;
`endif

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, ISSUE} state_t;
`endif

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;
  logic            req_q, req_d;
  logic            vld_q, vld_d;
`ifdef FETCH_HALT_EN
  logic            halted_q, halted_d;
`endif

  // Condition decode: flags are {N,C,V,Z}; cond[3]=1 never jumps.
  function automatic logic jump_taken(input logic [3:0] cond, input logic [3:0] flags);
    logic n, c, v, z;
    {n, c, v, z} = flags;
    if (cond[3]) return 1'b0;
    case (cond[2:0])
      3'd0:    return 1'b1;
      3'd1:    return 1'b1;
      3'd2:    return z;
      3'd3:    return !z;
      3'd4:    return c;
      3'd5:    return !c;
      3'd6:    return n;
      default: return v;
    endcase
  endfunction

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    vld_d   = vld_q;
`ifdef FETCH_HALT_EN
    halted_d = halted_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: begin
        if (i_Mem_Ack) begin
          ir_d    = i_Mem_Data;
          pc_d    = pc_q + PC_ONE;
          state_d = ISSUE;
          req_d   = 1'b0;
          vld_d   = 1'b1;
        end
      end
      ISSUE: begin
        if (!i_Stall) begin
          vld_d = 1'b0;
`ifdef FETCH_HALT_EN
          if (ir_q == HALT_INSTR) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            if (jump_taken(i_COND, i_Flags)) pc_d = i_Jump_Addr;
          end
`else
          state_d = REQ;
          req_d   = 1'b1;
          if (jump_taken(i_COND, i_Flags)) pc_d = i_Jump_Addr;
`endif
        end
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        req_d = 1'b0;
        vld_d = 1'b0;
      end
`endif
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        vld_d   = 1'b0;
      end
    endcase
  end

  // FSM state, PC, instruction register and registered outputs.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSTR;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
`ifdef FETCH_HALT_EN
      halted_q <= halted_d;
`endif
    end
  end

  assign o_Mem_Addr    = pc_q;
  assign o_PC_Return   = pc_q;
  assign o_Mem_Req     = req_q;
  assign o_Valid       = vld_q;
  assign o_Instruction = ir_q;
`ifdef FETCH_HALT_EN
  assign o_Halted      = halted_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder with a scoreboard of fetched words,
// compared when the decoder side consumes them. A bench PC model tracks the
// expected request addresses.
module tb_fetch_unit;
  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [PC_W-1:0] mem_addr;
  logic            mem_req;
  logic            mem_ack;
  logic [8:0]      mem_data;
  logic [8:0]      instr;
  logic            valid;
  logic            stall;
  logic [3:0]      cond;
  logic [3:0]      flags;
  logic [PC_W-1:0] jump_addr;
  logic [PC_W-1:0] pc_ret;
`ifdef FETCH_HALT_EN
  logic            halted;
`endif

  logic [8:0]      exp_q[$];
  logic [PC_W-1:0] mpc;
  int              n_chk = 0;
  int              n_pass = 0;

  fetch_unit #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .o_Mem_Addr(mem_addr),
    .o_Mem_Req(mem_req),
    .i_Mem_Ack(mem_ack),
    .i_Mem_Data(mem_data),
    .o_Instruction(instr),
    .o_Valid(valid),
    .i_Stall(stall),
    .i_COND(cond),
    .i_Flags(flags),
    .i_Jump_Addr(jump_addr),
    .o_PC_Return(pc_ret)
`ifdef FETCH_HALT_EN
    ,
    .o_Halted(halted)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, checks so far %0d", n_chk);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected jump decision; flags are {N,C,V,Z}.
  function automatic logic exp_taken(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'd0, 4'd1: return 1'b1;
      4'd2:       return f[0];
      4'd3:       return !f[0];
      4'd4:       return f[2];
      4'd5:       return !f[2];
      4'd6:       return f[3];
      4'd7:       return f[1];
      default:    return 1'b0;
    endcase
  endfunction

  // Wait for a request, check its address, hold it wait_n cycles, then ack.
  task automatic fetch_one(input logic [8:0] data, input int wait_n, input logic [PC_W-1:0] exp_addr);
    int guard;
    guard = 0;
    while (!mem_req && guard < 8) begin
      cyc();
      guard++;
    end
    chk("req_seen", 32'(mem_req), 32'(1));
    chk("req_addr", 32'(mem_addr), 32'(exp_addr));
    chk("no_vld_in_req", 32'(valid), 32'(0));
    for (int i = 0; i < wait_n; i++) begin
      cyc();
      chk("req_hold", 32'(mem_req), 32'(1));
      chk("addr_hold", 32'(mem_addr), 32'(exp_addr));
    end
    mem_ack  = 1'b1;
    mem_data = data;
    exp_q.push_back(data);
    cyc();
    mem_ack  = 1'b0;
    mem_data = 9'($urandom);
    chk("vld_after_ack", 32'(valid), 32'(1));
    chk("req_drop", 32'(mem_req), 32'(0));
  endtask

  // Stall for stall_n cycles (with a stray ack), then consume with the given condition.
  task automatic consume(input logic [3:0] c, input logic [3:0] f, input logic [PC_W-1:0] j,
                         input int stall_n, input logic [PC_W-1:0] exp_ret);
    logic [8:0] exp_ir;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'(1), 32'(0));
      exp_ir = 9'h000;
    end else begin
      exp_ir = exp_q.pop_front();
    end
    stall = 1'b1;
    for (int i = 0; i < stall_n; i++) begin
      mem_ack  = 1'b1;
      mem_data = 9'h0AA;
      cyc();
      chk("stall_vld", 32'(valid), 32'(1));
      chk("stall_ir", 32'(instr), 32'(exp_ir));
      chk("stall_pc", 32'(mem_addr), 32'(exp_ret));
      chk("stall_noreq", 32'(mem_req), 32'(0));
    end
    mem_ack   = 1'b0;
    stall     = 1'b0;
    cond      = c;
    flags     = f;
    jump_addr = j;
    chk("issue_vld", 32'(valid), 32'(1));
    chk("issue_ir", 32'(instr), 32'(exp_ir));
    chk("pc_return", 32'(pc_ret), 32'(exp_ret));
    cyc();
    cond      = 4'hF;
    flags     = 4'($urandom);
    jump_addr = 8'($urandom);
    chk("vld_clear", 32'(valid), 32'(0));
  endtask

  // One full instruction: fetch at the model PC, consume, update the model PC.
  task automatic step(input logic [8:0] data, input int wait_n, input int stall_n,
                      input logic [3:0] c, input logic [3:0] f, input logic [PC_W-1:0] j);
    fetch_one(data, wait_n, mpc);
    mpc = mpc + 8'd1;
    consume(c, f, j, stall_n, mpc);
    if (exp_taken(c, f)) mpc = j;
  endtask

  initial begin
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_data  = 9'h000;
    stall     = 1'b0;
    cond      = 4'hF;
    flags     = 4'h0;
    jump_addr = 8'h00;
    mpc       = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'(0));
    chk("rst_vld", 32'(valid), 32'(0));
    chk("rst_ir", 32'(instr), 32'(9'h1C0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_ret", 32'(pc_ret), 32'(0));
`ifdef FETCH_HALT_EN
    chk("rst_halted", 32'(halted), 32'(0));
`endif
    rst = 1'b0;
    cyc();
    chk("first_req", 32'(mem_req), 32'(1));

    // Zero-wait stream, no jumps.
    step(9'h008, 0, 0, 4'hF, 4'h0, 8'h80);
    step(9'h049, 0, 0, 4'hF, 4'hF, 8'h80);
    step(9'h112, 0, 0, 4'hF, 4'h1, 8'h80);
    // Three wait states at 0x03, then four stall cycles.
    step(9'h033, 3, 4, 4'hF, 4'h0, 8'h00);
    // Unconditional jump to 0x10, then Z-conditional jumps.
    step(9'h044, 0, 0, 4'h0, 4'h0, 8'h10);
    step(9'h101, 0, 0, 4'h2, 4'b0001, 8'h40);
    chk("jz_taken_pc", 32'(mpc), 32'(8'h40));
    step(9'h140, 0, 0, 4'h0, 4'h0, 8'h10);
    step(9'h101, 0, 0, 4'h2, 4'b1110, 8'h40);
    chk("jz_not_taken_pc", 32'(mpc), 32'(8'h11));
    // Call from 0x11 (return value 0x12) to 0xFF, then wrap to 0x00.
    step(9'h111, 0, 0, 4'h1, 4'h0, 8'hFF);
    step(9'h0FF, 1, 0, 4'hF, 4'h0, 8'h20);
    chk("wrap_pc", 32'(mpc), 32'(0));
    // Random condition codes, flags, waits and stalls.
    for (int k = 0; k < 24; k++) begin
      logic [3:0] rc;
      rc = (k % 3 == 2) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(2, 7));
      step(9'($urandom_range(0, 9'h1FE)), $urandom_range(0, 2), $urandom_range(0, 2),
           rc, 4'($urandom), 8'($urandom));
    end

    // Reset during a request at 0x05, with an ack arriving under reset.
    step(9'h000, 0, 0, 4'h0, 4'h0, 8'h05);
    cyc();
    chk("pre_rst_req", 32'(mem_req), 32'(1));
    chk("pre_rst_addr", 32'(mem_addr), 32'(8'h05));
    #4;
    rst      = 1'b1;
    mem_ack  = 1'b1;
    mem_data = 9'h055;
    #1;
    chk("async_req", 32'(mem_req), 32'(0));
    chk("async_vld", 32'(valid), 32'(0));
    chk("async_ir", 32'(instr), 32'(9'h1C0));
    chk("async_addr", 32'(mem_addr), 32'(0));
    cyc();
    chk("ack_under_rst_ir", 32'(instr), 32'(9'h1C0));
    mem_ack = 1'b0;
    rst     = 1'b0;
    exp_q.delete();
    mpc = 8'h00;
    chk("post_rst_idle", 32'(mem_req), 32'(0));
    cyc();
    chk("post_rst_req", 32'(mem_req), 32'(1));
    chk("post_rst_addr", 32'(mem_addr), 32'(0));
    step(9'h0C3, 0, 1, 4'hF, 4'h0, 8'h00);

`ifdef FETCH_HALT_EN
    // Halt opcode still reaches the decoder, then everything stops.
    step(9'h1FF, 0, 0, 4'hF, 4'h0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("halt_flag", 32'(halted), 32'(1));
      chk("halt_noreq", 32'(mem_req), 32'(0));
      chk("halt_novld", 32'(valid), 32'(0));
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("halt_rst_clear", 32'(halted), 32'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
